// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg : shared RISC8 definitions used by the fetch stage and decoder.
//   - NOP constant and opcode mask/pattern pairs for GOTO, CALL, RETLW, SLEEP
//   - RUN/SLEEP state encoding
//   - PCL file-register address
//   - op_match() helper for masked opcode compares
// ---------------------------------------------------------------------------
package ifetch_pkg;

  localparam logic [11:0] NOP        = 12'h000;

  // GOTO 101k_kkkk_kkkk
  localparam logic [11:0] GOTO_MASK  = 12'hE00;
  localparam logic [11:0] GOTO_PAT   = 12'hA00;
  // CALL 1001_kkkk_kkkk
  localparam logic [11:0] CALL_MASK  = 12'hF00;
  localparam logic [11:0] CALL_PAT   = 12'h900;
  // RETLW 1000_kkkk_kkkk
  localparam logic [11:0] RETLW_MASK = 12'hF00;
  localparam logic [11:0] RETLW_PAT  = 12'h800;
  // SLEEP 0000_0000_0011
  localparam logic [11:0] SLEEP_MASK = 12'hFFF;
  localparam logic [11:0] SLEEP_PAT  = 12'h003;

  localparam logic [4:0]  PCL_ADDR   = 5'd2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_SLEEP = 1'b1
  } state_t;

  function automatic logic op_match(input logic [11:0] inst,
                                    input logic [11:0] mask,
                                    input logic [11:0] pat);
    return (inst & mask) == pat;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// ---------------------------------------------------------------------------
// ifetch_if : program-memory / decoder / datapath signals of the fetch stage.
//   master : the fetch stage (drives paddr, inst, sleeping, stack_ovf)
//   slave  : the surroundings (drive pdata, skip, pcl_we, pcl_data,
//            status_pa, wake)
// ---------------------------------------------------------------------------
interface ifetch_if #(
  parameter int PC_WIDTH = 11
);
  logic [PC_WIDTH-1:0] paddr;
  logic [11:0]         pdata;
  logic [11:0]         inst;
  logic                skip;
  logic                pcl_we;
  logic [7:0]          pcl_data;
  logic [1:0]          status_pa;
  logic                wake;
  logic                sleeping;
  logic                stack_ovf;

  modport master (
    output paddr, inst, sleeping, stack_ovf,
    input  pdata, skip, pcl_we, pcl_data, status_pa, wake
  );

  modport slave (
    input  paddr, inst, sleeping, stack_ovf,
    output pdata, skip, pcl_we, pcl_data, status_pa, wake
  );
endinterface

// File: rtl/ifetch_pcstack.sv
// ---------------------------------------------------------------------------
// pcstack : two-level hardware return stack.
//   clk, reset   : clock, asynchronous active-high reset
//   i_push/i_din : push i_din (stk2 <= stk1, stk1 <= i_din)
//   i_pop        : pop (stk1 <= stk2, stk2 unchanged)
//   o_top        : current stk1
//   o_ovf        : registered pulse, push while already two deep
// ---------------------------------------------------------------------------
module pcstack #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_top,
  output logic         o_ovf
);

  logic [W-1:0] r_stk1;
  logic [W-1:0] r_stk2;
  logic [1:0]   r_depth;
  logic         r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stk1  <= '0;
      r_stk2  <= '0;
      r_depth <= 2'd0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= i_push && (r_depth == 2'd2);
      if (i_push) begin
        r_stk2 <= r_stk1;
        r_stk1 <= i_din;
        if (r_depth != 2'd2) r_depth <= r_depth + 2'd1;
      end else if (i_pop) begin
        // stk2 is left in place, so underflowing pops keep returning it
        r_stk1 <= r_stk2;
        if (r_depth != 2'd0) r_depth <= r_depth - 2'd1;
      end
    end
  end

  assign o_top = r_stk1;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch : RISC8 instruction fetch stage (PC, return stack, instruction reg).
//   clk    : clock
//   reset  : asynchronous active-high reset
//   bus    : ifetch_if.master
//     paddr     out  program-memory address (= PC)
//     pdata     in   program word at paddr (combinational)
//     inst      out  executing instruction
//     skip      in   skip condition for inst
//     pcl_we    in   inst writes PCL
//     pcl_data  in   value written to PCL
//     status_pa in   page bits -> PC[10:9]
//     wake      in   leave SLEEP
//     sleeping  out  in SLEEP state
//     stack_ovf out  pulse on push into a full stack
// ---------------------------------------------------------------------------
module ifetch
  import ifetch_pkg::*;
#(
  parameter int                    PC_WIDTH     = 11,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '1
) (
  input  logic     clk,
  input  logic     reset,
  ifetch_if.master bus
);

  logic [PC_WIDTH-1:0] r_pc;
  logic [11:0]         r_inst;
  state_t              r_state;

  logic [PC_WIDTH-1:0] w_pc_next;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [11:0]         w_inst_next;
  state_t              w_state_next;
  logic                w_push;
  logic                w_pop;
  logic [PC_WIDTH-1:0] w_top;
  logic                w_ovf;

  logic w_is_goto;
  logic w_is_call;
  logic w_is_retlw;
  logic w_is_sleep;

  assign w_is_goto  = op_match(r_inst, GOTO_MASK,  GOTO_PAT);
  assign w_is_call  = op_match(r_inst, CALL_MASK,  CALL_PAT);
  assign w_is_retlw = op_match(r_inst, RETLW_MASK, RETLW_PAT);
  assign w_is_sleep = op_match(r_inst, SLEEP_MASK, SLEEP_PAT);

  assign w_pc_inc = r_pc + PC_WIDTH'(1);

  pcstack #(.W(PC_WIDTH)) u_stack (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  (r_pc),
    .o_top  (w_top),
    .o_ovf  (w_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_VECTOR;
      r_inst  <= NOP;
      r_state <= ST_RUN;
    end else begin
      r_pc    <= w_pc_next;
      r_inst  <= w_inst_next;
      r_state <= w_state_next;
    end
  end

  // Every redirect leaves inst = NOP, which flushes the word fetched
  // from the old PC. r_pc already points past the executing instruction,
  // so it is the CALL return address.
  always_comb begin
    w_pc_next    = r_pc;
    w_inst_next  = NOP;
    w_state_next = r_state;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_is_goto) begin
          w_pc_next = PC_WIDTH'({bus.status_pa, r_inst[8:0]});
        end else if (w_is_call) begin
          w_push    = 1'b1;
          w_pc_next = PC_WIDTH'({bus.status_pa, 1'b0, r_inst[7:0]});
        end else if (w_is_retlw) begin
          w_pop     = 1'b1;
          w_pc_next = w_top;
        end else if (w_is_sleep) begin
          w_state_next = ST_SLEEP;
        end else if (bus.pcl_we) begin
          w_pc_next = PC_WIDTH'({bus.status_pa, 1'b0, bus.pcl_data});
        end else if (bus.skip) begin
          w_pc_next = w_pc_inc;
        end else begin
          w_pc_next   = w_pc_inc;
          w_inst_next = bus.pdata;
        end
      end
      ST_SLEEP: begin
        // The word at the held PC (after SLEEP) becomes the first executed
        if (bus.wake) begin
          w_pc_next    = w_pc_inc;
          w_inst_next  = bus.pdata;
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign bus.paddr     = r_pc;
  assign bus.inst      = r_inst;
  assign bus.sleeping  = (r_state == ST_SLEEP);
  assign bus.stack_ovf = w_ovf;

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ifetch_if #(.PC_WIDTH(11)) bus ();

  logic [11:0] mem [0:2047];
  assign bus.pdata = mem[bus.paddr];

  ifetch #(.PC_WIDTH(11), .RESET_VECTOR(11'h7FF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic clear_inputs();
    bus.skip      = 1'b0;
    bus.pcl_we    = 1'b0;
    bus.pcl_data  = 8'h00;
    bus.status_pa = 2'b00;
    bus.wake      = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 12'h000;
  endtask

  // Reset, then release 1 time unit after a rising edge: cycle 0 is sampled here.
  task automatic start_run();
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_mem();
    mem[11'h7FF] = 12'hA05;
    start_run();
    $display("reset: released paddr=%h inst=%h sleeping=%b ovf=%b",
             bus.paddr, bus.inst, bus.sleeping, bus.stack_ovf);
    n_checks++;
    if (bus.paddr !== 11'h7FF) begin
      n_fail++; $display("FAIL reset_paddr: got %h want 7ff", bus.paddr);
    end
    n_checks++;
    if (bus.inst !== 12'h000) begin
      n_fail++; $display("FAIL reset_inst: got %h want 000", bus.inst);
    end
    n_checks++;
    if (bus.sleeping !== 1'b0 || bus.stack_ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got sleeping=%b ovf=%b want 0 0",
                         bus.sleeping, bus.stack_ovf);
    end
    // GOTO now in inst: reset mid-redirect must take effect without a clock
    step();
    #2;
    reset = 1'b1;
    #1;
    $display("reset: mid-redirect paddr=%h inst=%h", bus.paddr, bus.inst);
    n_checks++;
    if (bus.paddr !== 11'h7FF || bus.inst !== 12'h000) begin
      n_fail++; $display("FAIL reset_async: got paddr=%h inst=%h want 7ff 000",
                         bus.paddr, bus.inst);
    end
    step();
    n_checks++;
    if (bus.paddr !== 11'h7FF) begin
      n_fail++; $display("FAIL reset_hold: got %h want 7ff", bus.paddr);
    end
    reset = 1'b0;
  endtask

  task automatic test_goto();
    logic [10:0] ep [5] = '{11'h7FF, 11'h000, 11'h005, 11'h006, 11'h007};
    logic [11:0] ei [5] = '{12'h000, 12'hA05, 12'h000, 12'h123, 12'h456};
    clear_mem();
    mem[11'h7FF] = 12'hA05;
    mem[11'h005] = 12'h123;
    mem[11'h006] = 12'h456;
    start_run();
    for (int c = 0; c < 5; c++) begin
      $display("goto: c%0d paddr=%h inst=%h", c, bus.paddr, bus.inst);
      n_checks++;
      if (bus.paddr !== ep[c] || bus.inst !== ei[c]) begin
        n_fail++; $display("FAIL goto c%0d: got paddr=%h inst=%h want %h %h",
                           c, bus.paddr, bus.inst, ep[c], ei[c]);
      end
      step();
    end
  endtask

  task automatic test_call_ret();
    logic [10:0] ep [9] = '{11'h7FF, 11'h000, 11'h010, 11'h011, 11'h240,
                            11'h241, 11'h011, 11'h012, 11'h000};
    logic [11:0] ei [9] = '{12'h000, 12'hA10, 12'h000, 12'h940, 12'h000,
                            12'h8AB, 12'h000, 12'h800, 12'h000};
    clear_mem();
    mem[11'h7FF] = 12'hA10;
    mem[11'h010] = 12'h940;
    mem[11'h240] = 12'h8AB;
    mem[11'h011] = 12'h800;
    start_run();
    for (int c = 0; c < 9; c++) begin
      $display("call_ret: c%0d paddr=%h inst=%h", c, bus.paddr, bus.inst);
      n_checks++;
      if (bus.paddr !== ep[c] || bus.inst !== ei[c]) begin
        n_fail++; $display("FAIL call_ret c%0d: got paddr=%h inst=%h want %h %h",
                           c, bus.paddr, bus.inst, ep[c], ei[c]);
      end
      if (c == 3) bus.status_pa = 2'b01;
      step();
    end
  endtask

  task automatic test_nested();
    logic [10:0] ep [17] = '{11'h7FF, 11'h000, 11'h100, 11'h101, 11'h200,
                             11'h201, 11'h2F0, 11'h2F1, 11'h300, 11'h301,
                             11'h250, 11'h251, 11'h301, 11'h302, 11'h201,
                             11'h202, 11'h201};
    logic [11:0] ei [17] = '{12'h000, 12'hB00, 12'h000, 12'h900, 12'h000,
                             12'h9F0, 12'h000, 12'hB00, 12'h000, 12'h950,
                             12'h000, 12'h800, 12'h000, 12'h800, 12'h000,
                             12'h800, 12'h000};
    clear_mem();
    mem[11'h7FF] = 12'hB00;
    mem[11'h100] = 12'h900;
    mem[11'h200] = 12'h9F0;
    mem[11'h2F0] = 12'hB00;
    mem[11'h300] = 12'h950;
    mem[11'h250] = 12'h800;
    mem[11'h301] = 12'h800;
    mem[11'h201] = 12'h800;
    start_run();
    for (int c = 0; c < 17; c++) begin
      $display("nested: c%0d paddr=%h inst=%h ovf=%b",
               c, bus.paddr, bus.inst, bus.stack_ovf);
      n_checks++;
      if (bus.paddr !== ep[c] || bus.inst !== ei[c]) begin
        n_fail++; $display("FAIL nested c%0d: got paddr=%h inst=%h want %h %h",
                           c, bus.paddr, bus.inst, ep[c], ei[c]);
      end
      n_checks++;
      if (bus.stack_ovf !== (c == 10)) begin
        n_fail++; $display("FAIL nested_ovf c%0d: got %b want %b",
                           c, bus.stack_ovf, (c == 10));
      end
      if (c == 2) bus.status_pa = 2'b01;
      step();
    end
  endtask

  task automatic test_skip_pcl();
    logic [10:0] ep [8] = '{11'h7FF, 11'h000, 11'h020, 11'h021, 11'h022,
                            11'h023, 11'h480, 11'h481};
    logic [11:0] ei [8] = '{12'h000, 12'hA20, 12'h000, 12'h2E5, 12'h000,
                            12'h022, 12'h000, 12'h456};
    clear_mem();
    mem[11'h7FF] = 12'hA20;
    mem[11'h020] = 12'h2E5;
    mem[11'h021] = 12'h123;
    mem[11'h022] = 12'h022;
    mem[11'h480] = 12'h456;
    start_run();
    for (int c = 0; c < 8; c++) begin
      $display("skip_pcl: c%0d paddr=%h inst=%h", c, bus.paddr, bus.inst);
      n_checks++;
      if (bus.paddr !== ep[c] || bus.inst !== ei[c]) begin
        n_fail++; $display("FAIL skip_pcl c%0d: got paddr=%h inst=%h want %h %h",
                           c, bus.paddr, bus.inst, ep[c], ei[c]);
      end
      clear_inputs();
      case (c)
        1: bus.skip = 1'b1;       // ignored: GOTO in inst
        3: bus.skip = 1'b1;       // DECFSZ result zero
        5: begin
          bus.pcl_we    = 1'b1;
          bus.pcl_data  = 8'h80;
          bus.status_pa = 2'b10;
        end
        default: ;
      endcase
      step();
    end
  endtask

  task automatic test_sleep();
    logic [10:0] ep;
    logic [11:0] ei;
    logic        es;
    clear_mem();
    mem[11'h7FF] = 12'hA30;
    mem[11'h030] = 12'h003;
    mem[11'h031] = 12'h5A5;
    mem[11'h032] = 12'h003;
    start_run();
    for (int c = 0; c < 18; c++) begin
      es = 1'b0;
      ei = 12'h000;
      if (c == 0)       ep = 11'h7FF;
      else if (c == 1) begin ep = 11'h000; ei = 12'hA30; end
      else if (c == 2)  ep = 11'h030;
      else if (c == 3) begin ep = 11'h031; ei = 12'h003; end
      else if (c <= 14) begin ep = 11'h031; es = 1'b1; end
      else if (c == 15) begin ep = 11'h032; ei = 12'h5A5; end
      else if (c == 16) begin ep = 11'h033; ei = 12'h003; end
      else begin ep = 11'h033; es = 1'b1; end
      $display("sleep: c%0d paddr=%h inst=%h sleeping=%b",
               c, bus.paddr, bus.inst, bus.sleeping);
      n_checks++;
      if (bus.paddr !== ep || bus.inst !== ei || bus.sleeping !== es) begin
        n_fail++; $display("FAIL sleep c%0d: got paddr=%h inst=%h sleeping=%b want %h %h %b",
                           c, bus.paddr, bus.inst, bus.sleeping, ep, ei, es);
      end
      clear_inputs();
      if (c == 2 || c == 3) bus.wake = 1'b1;          // wake in RUN: no effect
      if (c >= 5 && c <= 13) begin                    // ignored while asleep
        bus.skip     = 1'b1;
        bus.pcl_we   = 1'b1;
        bus.pcl_data = 8'h80;
      end
      if (c == 14) bus.wake = 1'b1;
      if (c != 17) step();
    end
    #2;
    reset = 1'b1;
    #1;
    $display("sleep: reset while asleep paddr=%h sleeping=%b", bus.paddr, bus.sleeping);
    n_checks++;
    if (bus.paddr !== 11'h7FF || bus.sleeping !== 1'b0 || bus.inst !== 12'h000) begin
      n_fail++; $display("FAIL sleep_reset: got paddr=%h sleeping=%b inst=%h want 7ff 0 000",
                         bus.paddr, bus.sleeping, bus.inst);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    logic [10:0] ep [8] = '{11'h7FF, 11'h000, 11'h001, 11'h002, 11'h7FE,
                            11'h7FF, 11'h000, 11'h001};
    logic [11:0] ei [8] = '{12'h000, 12'h222, 12'h333, 12'hBFE, 12'h000,
                            12'h111, 12'h222, 12'h333};
    clear_mem();
    mem[11'h7FF] = 12'h222;
    mem[11'h000] = 12'h333;
    mem[11'h001] = 12'hBFE;
    mem[11'h7FE] = 12'h111;
    start_run();
    for (int c = 0; c < 8; c++) begin
      $display("wrap: c%0d paddr=%h inst=%h", c, bus.paddr, bus.inst);
      n_checks++;
      if (bus.paddr !== ep[c] || bus.inst !== ei[c]) begin
        n_fail++; $display("FAIL wrap c%0d: got paddr=%h inst=%h want %h %h",
                           c, bus.paddr, bus.inst, ep[c], ei[c]);
      end
      bus.status_pa = (c == 3) ? 2'b11 : 2'b00;
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    clear_mem();
    test_reset();
    test_goto();
    test_call_ret();
    test_nested();
    test_skip_pcl();
    test_sleep();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage of the RISC8 (PIC16C5x-class) core. It owns the program counter, the two-level return stack and the instruction register. It drives the program-memory address and presents the executing 12-bit instruction to the instruction decoder. It resolves GOTO/CALL/RETLW, PCL writes, skips and SLEEP by redirecting the PC and flushing the fetched word to NOP.

## Interface
Parameters:
- `PC_WIDTH`, 11, program counter / program-memory address width (2K words).
- `RESET_VECTOR`, all ones (11'h7FF), PC value after reset.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `paddr`  out  PC_WIDTH  program-memory address; equals the PC register.
- `pdata`  in  12  program-memory word at `paddr`; combinational read, valid in the same cycle.
- `inst`  out  12  executing instruction, fed to the decoder.
- `skip`  in  1  datapath skip condition (DECFSZ/INCFSZ zero result, BTFSC/BTFSS bit test true) for the instruction in `inst`.
- `pcl_we`  in  1  the instruction in `inst` writes file register 2 (PCL).
- `pcl_data`  in  8  value written to PCL.
- `status_pa`  in  2  STATUS[6:5] page-select bits, which supply PC[10:9].
- `wake`  in  1  wake request; only acted on while sleeping.
- `sleeping`  out  1  high while in the SLEEP state.
- `stack_ovf`  out  1  one-cycle pulse when a CALL overwrites a live level-2 entry.

## Operation
- Two-stage pipeline: while `inst` executes, `pdata` at `paddr` is fetched. Every redirect loads NOP (12'h000) into `inst`, so a redirect costs 2 cycles.
- Reset values (asynchronous): PC = RESET_VECTOR, `inst` = NOP, stack entries = 0, depth = 0, state = RUN, `sleeping` = 0, `stack_ovf` = 0.
- The block decodes these opcodes from `inst` itself:
  - GOTO `101k_kkkk_kkkk`
  - CALL `1001_kkkk_kkkk`
  - RETLW `1000_kkkk_kkkk`
  - SLEEP `0000_0000_0011`
- Next-PC priority, highest first, in RUN:
  1. GOTO: PC = {status_pa, k[8:0]}.
  2. CALL: push PC, then PC = {status_pa, 1'b0, k[7:0]}.
  3. RETLW: PC = top of stack, then pop.
  4. SLEEP: PC holds, state goes to SLEEP.
  5. `pcl_we`: PC = {status_pa, 1'b0, pcl_data}.
  6. `skip`: PC = PC+1 and `inst` = NOP.
  7. Otherwise: PC = PC+1 and `inst` = `pdata`.
- Cases 1–5 also load `inst` = NOP. `skip`/`pcl_we` asserted during a GOTO/CALL/RETLW/SLEEP are ignored.
- PC arithmetic is modulo 2^PC_WIDTH: 11'h7FF+1 = 11'h000.
- Stack:
  - Registers are `stk1` (top) and `stk2`, plus a depth counter of 0..2.
  - Push: `stk2` = `stk1`, `stk1` = PC (the address after the CALL), depth = min(depth+1, 2).
  - `stack_ovf` pulses when a push happens at depth 2; the old `stk2` is lost.
  - Pop: PC = `stk1`, `stk1` = `stk2`, `stk2` unchanged, depth = max(depth-1, 0).
  - Underflow is not an error: repeated RETLW keeps returning the `stk2` value.
- State machine, two states:
  - RUN: normal operation.
  - SLEEP: PC holds, `inst` stays NOP, `sleeping` = 1, `skip`/`pcl_we` ignored.
  - SLEEP → RUN on `wake` = 1: on that edge `inst` = `pdata`, PC = PC+1, `sleeping` drops. The instruction after SLEEP is therefore the first one executed.
  - `wake` while in RUN has no effect.
- `reset` mid-operation, including during SLEEP or mid-redirect, forces the reset values immediately.

## Timing
- Latency from `paddr` to `inst` is 1 clock.
- A redirect presents the target instruction 2 clocks after the redirecting instruction appeared in `inst`.
- `sleeping` is registered: it rises on the edge that retires SLEEP and falls on the edge that samples `wake`.
- `stack_ovf` is registered: high for exactly the cycle after the overflowing push edge.
- `skip`, `pcl_we`, `pcl_data`, `status_pa` and `wake` are sampled on the rising edge and must be valid in the same cycle as the corresponding `inst`.

## Structure
- Shared RISC8 definitions header, also used by the decoder, holds:
  - NOP constant and opcode match patterns for GOTO, CALL, RETLW, SLEEP.
  - RUN/SLEEP state encodings.
  - PCL file address (2).
- Sub-module `pcstack`: the two-level stack with push, pop, top, depth and overflow pulse.

## Test plan
- Reset, then release: `paddr` = 7FF and `inst` = 000. With `pdata` = A05 (GOTO 005) at 7FF, `status_pa` = 00: one cycle later `paddr` = 000, the next `inst` = 000 (NOP), then `paddr` = 005.
- CALL 0x40 fetched at 0x010 (`status_pa` = 01): PC = 0x240, `stk1` = 0x011. RETLW at 0x240: PC = 0x011, one NOP bubble, depth back to 0.
- Three nested CALLs from 0x100, 0x200, 0x300: `stack_ovf` pulses once, on the third. Three RETLWs return 0x301, 0x201, 0x201.
- `skip` = 1 while `inst` = DECFSZ at 0x020: the following `inst` = NOP and PC advances 0x021 → 0x022 without a redirect. Also `pcl_we` = 1 with `pcl_data` = 0x80, `status_pa` = 10: PC = 0x480.
- SLEEP at 0x030: `sleeping` = 1 and `paddr` holds 0x031 for 10 cycles. `wake` pulse: `inst` = word at 0x031, PC = 0x032. Assert `reset` during SLEEP: immediate PC = 7FF, `sleeping` = 0.
- Wrap-around: straight-line code at 0x7FE with no redirects: `paddr` sequence is 7FF, 000, 001.
